// File: rtl/cardinal_hdu_pkg.sv
// Shared constants and types for the Cardinal scoreboard hazard detection unit.
// The entry struct carries a fixed-width countdown; entries narrow it internally.
package cardinal_hdu_pkg;

  localparam int REG_AW    = 5;
  localparam int ENT_CNT_W = 4;

  localparam logic [5:0] OP_R   = 6'b101010;
  localparam logic [5:0] OP_LD  = 6'b100000;
  localparam logic [5:0] OP_BEQ = 6'b100010;
  localparam logic [5:0] OP_BNE = 6'b100011;

  typedef struct packed {
    logic                 busy;
    logic                 is_ld;
    logic [ENT_CNT_W-1:0] cnt;
  } hdu_entry_t;

  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hdu_scoreboard_if.sv
// Pipeline-to-HDU signal bundle: the pipeline is the master, the scoreboard the slave.
interface hdu_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int SCNT_W   = 16
) ();

  logic              id_valid;
  logic              id_flush;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              ld_done;
  logic [REG_AW-1:0] ld_done_rd;
  logic                pc_stall;
  logic                if_id_stall;
  logic                id_ex_bubble;
  logic [NUM_REGS-1:0] busy_vec;
  logic [SCNT_W-1:0]   stall_cycles;
  logic                err_ld_done;

  modport master (
    output id_valid, id_flush, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, ld_done, ld_done_rd,
    input  pc_stall, if_id_stall, id_ex_bubble, busy_vec, stall_cycles, err_ld_done
  );

  modport slave (
    input  id_valid, id_flush, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, ld_done, ld_done_rd,
    output pc_stall, if_id_stall, id_ex_bubble, busy_vec, stall_cycles, err_ld_done
  );

endinterface

// File: rtl/hdu_sb_entry.sv
// One scoreboard entry: a new producer beats any same-edge countdown or load completion.
module hdu_sb_entry
  import cardinal_hdu_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_set,
  input  logic       i_set_ld,
  input  logic       i_ld_clr,
  output hdu_entry_t o_entry
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(ALU_LAT);

  logic             r_busy;
  logic             r_isLd;
  logic [CNT_W-1:0] r_cnt;

  // ALU entries retire on the edge where the countdown reaches one; loads wait for completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_isLd <= 1'b0;
      r_cnt  <= '0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_isLd <= i_set_ld;
      r_cnt  <= i_set_ld ? '0 : LAT;
    end else if (r_busy && !r_isLd) begin
      if (r_cnt <= CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else if (r_busy && r_isLd && i_ld_clr) begin
      r_busy <= 1'b0;
    end
  end

  assign o_entry = '{busy: r_busy, is_ld: r_isLd, cnt: ENT_CNT_W'(r_cnt)};

endmodule

// File: rtl/hdu_scoreboard.sv
// Scoreboard hazard detection unit: stalls PC and IF/ID while any source operand
// is still in flight, tracking ALU results by countdown and loads by completion.
module hdu_scoreboard
  import cardinal_hdu_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ALU_LAT    = 2,
  parameter int BYPASS_LAT = 0,
  parameter int MAX_LOADS  = 2,
  parameter bit R0_ZERO    = 1'b0,
  parameter int SCNT_W     = 16
) (
  input logic            clk,
  input logic            reset,
  hdu_scoreboard_if.slave bus
);

  localparam int CNT_W = cnt_width(ALU_LAT);
  localparam int LDC_W = $clog2(MAX_LOADS + 1);

  hdu_entry_t          w_ent [NUM_REGS];
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy;
  logic                w_haz1;
  logic                w_haz2;
  logic                w_ldFull;
  logic                w_stall;
  logic                w_pcStall;
  logic                w_issue;
  logic                w_ldIssue;
  logic                w_ldOk;
  logic [LDC_W-1:0]    r_ldCnt;
  logic [SCNT_W-1:0]   r_stallCnt;
  logic                r_err;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ent
    localparam bit TRACK = !(R0_ZERO && g == 0);
    assign w_set[g]  = TRACK && w_issue && bus.id_rd_we && (bus.id_rd == REG_AW'(g));
    assign w_clr[g]  = TRACK && bus.ld_done && (bus.ld_done_rd == REG_AW'(g));
    assign w_busy[g] = w_ent[g].busy;
    hdu_sb_entry #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) u_entry (
      .clk     (clk),
      .reset   (reset),
      .i_set   (w_set[g]),
      .i_set_ld(bus.id_is_load),
      .i_ld_clr(w_clr[g]),
      .o_entry (w_ent[g])
    );
  end

  // Decision uses registered state only, so same-cycle completions release a cycle later
  always_comb begin
    w_haz1 = bus.id_rs1_used && w_ent[bus.id_rs1].busy &&
             (w_ent[bus.id_rs1].is_ld || w_ent[bus.id_rs1].cnt > ENT_CNT_W'(BYPASS_LAT));
    w_haz2 = bus.id_rs2_used && w_ent[bus.id_rs2].busy &&
             (w_ent[bus.id_rs2].is_ld || w_ent[bus.id_rs2].cnt > ENT_CNT_W'(BYPASS_LAT));
    w_ldFull  = (r_ldCnt == LDC_W'(MAX_LOADS));
    w_stall   = !reset && bus.id_valid &&
                (w_haz1 || w_haz2 || (bus.id_is_load && bus.id_rd_we && w_ldFull));
    w_pcStall = w_stall && !bus.id_flush;
    w_issue   = bus.id_valid && !w_stall && !bus.id_flush;
    w_ldIssue = w_issue && bus.id_rd_we && bus.id_is_load;
    w_ldOk    = bus.ld_done && w_ent[bus.ld_done_rd].busy && w_ent[bus.ld_done_rd].is_ld;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ldCnt    <= '0;
      r_stallCnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case ({w_ldIssue, w_ldOk})
        2'b10:   if (r_ldCnt < LDC_W'(MAX_LOADS)) r_ldCnt <= r_ldCnt + LDC_W'(1);
        2'b01:   if (r_ldCnt != '0) r_ldCnt <= r_ldCnt - LDC_W'(1);
        default: r_ldCnt <= r_ldCnt;
      endcase
      if (w_pcStall && r_stallCnt != '1) r_stallCnt <= r_stallCnt + SCNT_W'(1);
      if (bus.ld_done && !w_ldOk) r_err <= 1'b1;
    end
  end

  assign bus.pc_stall     = w_pcStall;
  assign bus.if_id_stall  = w_pcStall;
  assign bus.id_ex_bubble = w_pcStall && !bus.id_flush;
  assign bus.busy_vec     = w_busy;
  assign bus.stall_cycles = r_stallCnt;
  assign bus.err_ld_done  = r_err;

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// model that tracks per-register ready cycles and outstanding loads.
module tb_hdu_scoreboard;

  localparam int NREG = 32;
  localparam int ALAT = 2;
  localparam int MAXL = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hdu_scoreboard_if dif ();
  hdu_scoreboard_if bif ();

  hdu_scoreboard #(.BYPASS_LAT(0)) dut (.clk(clk), .reset(reset), .bus(dif));
  hdu_scoreboard #(.BYPASS_LAT(1)) dutByp (.clk(clk), .reset(reset), .bus(bif));

  int errCnt = 0;
  int checkCnt = 0;

  // Model: register readable once the cycle passes aluEnd; loads pend until completed
  int cyc;
  int aluEnd [NREG];
  bit ldPend [NREG];
  int ldCnt;
  bit errExp;
  int stallExp;

  task checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mHaz(input int r, input bit used);
    return used && (ldPend[r] || cyc <= aluEnd[r]);
  endfunction

  function automatic logic [31:0] mBusyVec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) v[r] = ldPend[r] || (cyc <= aluEnd[r]);
    return v;
  endfunction

  task mReset();
    cyc = 0; ldCnt = 0; errExp = 1'b0; stallExp = 0;
    for (int r = 0; r < NREG; r++) begin
      aluEnd[r] = -100;
      ldPend[r] = 1'b0;
    end
  endtask

  task zeroInputs();
    dif.id_valid = 0; dif.id_flush = 0; dif.id_rs1 = 0; dif.id_rs2 = 0;
    dif.id_rs1_used = 0; dif.id_rs2_used = 0; dif.id_rd = 0; dif.id_rd_we = 0;
    dif.id_is_load = 0; dif.ld_done = 0; dif.ld_done_rd = 0;
    bif.id_valid = 0; bif.id_flush = 0; bif.id_rs1 = 0; bif.id_rs2 = 0;
    bif.id_rs1_used = 0; bif.id_rs2_used = 0; bif.id_rd = 0; bif.id_rd_we = 0;
    bif.id_is_load = 0; bif.ld_done = 0; bif.ld_done_rd = 0;
  endtask

  task doReset();
    @(negedge clk);
    reset = 1'b1;
    zeroInputs();
    #1;
    checkOutput("rst pc_stall", dif.pc_stall, 0);
    checkOutput("rst busy_vec", dif.busy_vec, 0);
    checkOutput("rst stall_cycles", dif.stall_cycles, 0);
    checkOutput("rst err", dif.err_ld_done, 0);
    @(negedge clk);
    reset = 1'b0;
    mReset();
  endtask

  task applyStimulus(input bit v, input bit fl, input int rs1, input bit u1,
                     input int rs2, input bit u2, input int rd, input bit we,
                     input bit ld, input bit dn, input int dnRd, output bit stallObs);
    bit stall, pcs, issue, ok;
    @(negedge clk);
    dif.id_valid = v; dif.id_flush = fl;
    dif.id_rs1 = 5'(rs1); dif.id_rs1_used = u1;
    dif.id_rs2 = 5'(rs2); dif.id_rs2_used = u2;
    dif.id_rd = 5'(rd); dif.id_rd_we = we; dif.id_is_load = ld;
    dif.ld_done = dn; dif.ld_done_rd = 5'(dnRd);
    #1;
    stall = v && (mHaz(rs1, u1) || mHaz(rs2, u2) || (ld && we && ldCnt == MAXL));
    pcs   = stall && !fl;
    issue = v && !stall && !fl;
    checkOutput("pc_stall", dif.pc_stall, pcs);
    checkOutput("if_id_stall", dif.if_id_stall, pcs);
    checkOutput("id_ex_bubble", dif.id_ex_bubble, pcs);
    checkOutput("busy_vec", dif.busy_vec, mBusyVec());
    checkOutput("stall_cycles", dif.stall_cycles, 64'(stallExp));
    checkOutput("err_ld_done", dif.err_ld_done, errExp);
    stallObs = dif.pc_stall;
    @(posedge clk);
    ok = dn && ldPend[dnRd];
    if (dn && !ok) errExp = 1'b1;
    if (ok) ldPend[dnRd] = 1'b0;
    if (issue && we) begin
      if (ld) begin
        ldPend[rd] = 1'b1;
        aluEnd[rd] = -100;
      end else begin
        ldPend[rd] = 1'b0;
        aluEnd[rd] = cyc + ALAT;
      end
    end
    if (issue && we && ld) ldCnt++;
    if (ok) ldCnt--;
    if (pcs && stallExp != 65535) stallExp++;
    cyc++;
  endtask

  initial begin
    bit s;
    int n;
    int pend [$];
    bit v, fl, u1, u2, we, ld, dn;
    int rs1, rs2, rd, dnRd;

    reset = 1'b1;
    zeroInputs();
    mReset();
    doReset();

    // ALU producer then dependent consumer: two stall cycles
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, s);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, s);
      if (!s) break;
      n++;
    end
    checkOutput("t1 stallLen", 64'(n), 2);

    // Load with completion six cycles later
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, s);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 5, 1, 0, 0, 0, 0, 0, (i == 5), 5, s);
      n += int'(s);
    end
    checkOutput("t3 stallLen", 64'(n), 6);
    applyStimulus(1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, s);
    checkOutput("t3 release", s, 0);
    #1 checkOutput("t3 busy5", dif.busy_vec[5], 0);

    // Load-slot limit
    applyStimulus(1, 0, 0, 0, 0, 0, 10, 1, 1, 0, 0, s);
    applyStimulus(1, 0, 0, 0, 0, 0, 11, 1, 1, 0, 0, s);
    applyStimulus(1, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, s);
    checkOutput("t4 full", s, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 12, 1, 1, 1, 10, s);
    checkOutput("t4 sameCycleDone", s, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, s);
    checkOutput("t4 issue", s, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 13, 1, 1, 1, 11, s);
    checkOutput("t4 cntStillTwo", s, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 13, 1, 1, 0, 0, s);
    checkOutput("t4 issue2", s, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, s);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, s);

    // Flushed producer and stray load completion
    applyStimulus(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, s);
    checkOutput("t5 flushNoStall", s, 0);
    applyStimulus(1, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, s);
    checkOutput("t5 consumer", s, 0);
    #1 checkOutput("t5 busy7", dif.busy_vec[7], 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, s);
    #1 checkOutput("t5 err", dif.err_ld_done, 1);

    // Forwarding instance: one stall cycle
    doReset();
    @(negedge clk);
    bif.id_valid = 1; bif.id_rd = 5'd3; bif.id_rd_we = 1;
    #1 checkOutput("t2 producer", bif.pc_stall, 0);
    @(negedge clk);
    bif.id_rd_we = 0; bif.id_rs1 = 5'd3; bif.id_rs1_used = 1;
    #1 checkOutput("t2 stall", bif.pc_stall, 1);
    @(negedge clk);
    #1 checkOutput("t2 release", bif.pc_stall, 0);
    @(negedge clk);
    bif.id_valid = 0; bif.id_rs1_used = 0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      rs1 = $urandom_range(0, 7); u1 = $urandom_range(0, 1);
      rs2 = $urandom_range(0, 7); u2 = $urandom_range(0, 1);
      rd = $urandom_range(0, 7);
      we = ($urandom_range(0, 4) != 0);
      ld = ($urandom_range(0, 2) == 0);
      if (ldPend[rd]) we = 0;
      pend.delete();
      for (int r = 0; r < 8; r++) if (ldPend[r]) pend.push_back(r);
      dn = 0; dnRd = 0;
      if (pend.size() > 0 && $urandom_range(0, 3) == 0) begin
        dn = 1;
        dnRd = pend[$urandom_range(0, pend.size() - 1)];
      end else if ($urandom_range(0, 299) == 0) begin
        dn = 1;
        dnRd = $urandom_range(8, 15);
      end
      applyStimulus(v, fl, rs1, u1, rs2, u2, rd, we, ld, dn, dnRd, s);
    end

    // Reset with three entries busy and a stall active
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, s);
    applyStimulus(1, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0, s);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, s);
    applyStimulus(1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, s);
    @(negedge clk);
    #1;
    checkOutput("t6 preStall", dif.pc_stall, 1);
    checkOutput("t6 preBusy", dif.busy_vec, 32'h52);
    checkOutput("t6 preCnt", dif.stall_cycles, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6 pc_stall", dif.pc_stall, 0);
    checkOutput("t6 busy_vec", dif.busy_vec, 0);
    checkOutput("t6 stall_cycles", dif.stall_cycles, 0);
    @(negedge clk);
    reset = 1'b0;
    zeroInputs();
    mReset();

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
